// File: rtl/pong_vga_render_if.sv
// Game-state inputs and VGA pixel/sync outputs of the Pong renderer.
interface pong_vga_render_if;
  logic [9:0] ballx;
  logic [9:0] bally;
  logic [9:0] l_pos;
  logic [9:0] r_pos;
  logic       hsync;
  logic       vsync;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;
  logic       frame_tick;

  modport master (
    output ballx, bally, l_pos, r_pos,
    input  hsync, vsync, red, green, blue, frame_tick
  );

  modport slave (
    input  ballx, bally, l_pos, r_pos,
    output hsync, vsync, red, green, blue, frame_tick
  );
endinterface

// File: rtl/pong_vga_render.sv
// VGA timing generator and Pong sprite renderer: ball, two paddles and walls,
// drawn from per-frame snapshots of the game state.
module pong_vga_render #(
  parameter int unsigned HBP       = 144,
  parameter int unsigned HFP       = 784,
  parameter int unsigned VBP       = 31,
  parameter int unsigned VFP       = 511,
  parameter int unsigned HPIXELS   = 800,
  parameter int unsigned VLINES    = 521,
  parameter int unsigned HPULSE    = 96,
  parameter int unsigned VPULSE    = 2,
  parameter int unsigned BALL_SIZE = 8,
  parameter int unsigned PADDLE_W  = 10,
  parameter int unsigned PADDLE_H  = 100,
  parameter int unsigned WALL_T    = 4
) (
  input logic               clk,
  input logic               rst_n,
  pong_vga_render_if.slave  bus
);

  localparam int unsigned CW = 10;
  localparam int unsigned SW = 11;

  logic [CW-1:0] hc, vc;
  logic [CW-1:0] sx, sy, sl, sr;
  logic          hs, vs, tick;
  logic [7:0]    rgb;

  logic          h_last_c, v_last_c, snap_c;
  logic [SW-1:0] hx_c, vx_c, bx_c, by_c, lx_c, rx_c;
  logic          active_c, ball_c, lpad_c, rpad_c, wall_c;
  logic [7:0]    rgb_c;

  assign h_last_c = (hc == CW'(HPIXELS - 1));
  assign v_last_c = (vc == CW'(VLINES - 1));
  assign snap_c   = (vc == CW'(VFP)) && (hc == '0);

  // Pixel/line counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc <= '0;
      vc <= '0;
    end else if (h_last_c) begin
      hc <= '0;
      vc <= v_last_c ? '0 : vc + CW'(1);
    end else begin
      hc <= hc + CW'(1);
    end
  end

  // One extra bit so sprite extents never wrap back into the visible area
  assign hx_c = SW'(hc);
  assign vx_c = SW'(vc);
  assign bx_c = SW'(sx);
  assign by_c = SW'(sy);
  assign lx_c = SW'(sl);
  assign rx_c = SW'(sr);

  assign active_c = (hx_c >= SW'(HBP)) && (hx_c < SW'(HFP)) &&
                    (vx_c >= SW'(VBP)) && (vx_c < SW'(VFP));
  assign ball_c   = (hx_c >= bx_c) && (hx_c < bx_c + SW'(BALL_SIZE)) &&
                    (vx_c >= by_c) && (vx_c < by_c + SW'(BALL_SIZE));
  assign lpad_c   = (hx_c >= SW'(HBP + 75 - PADDLE_W)) && (hx_c < SW'(HBP + 75)) &&
                    (vx_c >= lx_c) && (vx_c < lx_c + SW'(PADDLE_H));
  assign rpad_c   = (hx_c >= SW'(HBP + 585)) && (hx_c < SW'(HBP + 585 + PADDLE_W)) &&
                    (vx_c >= rx_c) && (vx_c < rx_c + SW'(PADDLE_H));
  assign wall_c   = ((vx_c >= SW'(VBP + 55 - WALL_T)) && (vx_c < SW'(VBP + 55))) ||
                    ((vx_c >= SW'(VBP + 425)) && (vx_c < SW'(VBP + 425 + WALL_T)));

  // Colour select, ball over paddles over walls
  always_comb begin
    rgb_c = 8'h00;
    if (active_c) begin
      if (ball_c)                rgb_c = 8'hFF;
      else if (lpad_c)           rgb_c = 8'h1C;
      else if (rpad_c)           rgb_c = 8'h03;
      else if (wall_c)           rgb_c = 8'hE0;
    end
  end

  // Output registers and game-state snapshots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs   <= 1'b1;
      vs   <= 1'b1;
      rgb  <= 8'h00;
      tick <= 1'b0;
      sx   <= CW'(HBP + 320);
      sy   <= CW'(VBP + 240);
      sl   <= CW'(VBP + 190);
      sr   <= CW'(VBP + 190);
    end else begin
      hs   <= (hc >= CW'(HPULSE));
      vs   <= (vc >= CW'(VPULSE));
      rgb  <= rgb_c;
      tick <= snap_c;
      if (snap_c) begin
        sx <= bus.ballx;
        sy <= bus.bally;
        sl <= bus.l_pos;
        sr <= bus.r_pos;
      end
    end
  end

  assign bus.hsync      = hs;
  assign bus.vsync      = vs;
  assign bus.red        = rgb[7:5];
  assign bus.green      = rgb[4:2];
  assign bus.blue       = rgb[1:0];
  assign bus.frame_tick = tick;

endmodule
